// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 4-digit 7-segment display decoder (optional blink detect: SEG_DECODE_BLINK_EN)
module seg_scan_decoder #(
    parameter int BLINK_TIMEOUT = 255
) (
    input  logic       clk_fst,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [3:0] an,
    output logic [6:0] pile_size,
    output logic       pile_vld,
    output logic       plr_turn,
    output logic       frame_vld,
    output logic       sync_err,
    output logic       win_det
);

    typedef enum logic [1:0] {
        WAIT_D0 = 2'd0,
        GOT_D0  = 2'd1,
        GOT_D1  = 2'd2,
        GOT_D2  = 2'd3
    } state_t;

    localparam logic [3:0] C_ONE_DP = 4'd11;
    localparam logic [3:0] C_TWO_DP = 4'd12;
    localparam logic [3:0] C_P      = 4'd13;
    localparam logic [3:0] C_BLANK  = 4'd14;
    localparam logic [3:0] C_BAD    = 4'd15;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] code;
    logic [3:0] d0_code;
    logic [3:0] d1_code;
    logic [3:0] d2_code;
    logic       cap_d0;
    logic       cap_d1;
    logic       cap_d2;
    logic       frame_done;
    logic       order_err;
    logic       lit_frame;
    logic       blank_frame;
    logic       bad_frame;
    logic       digits_num;
    logic [6:0] value;

    // Segment pattern to digit code; segments are active-low, bit 7 is the DP
    always_comb begin
        code = C_BAD;
        case (seg)
            8'hC0:   code = 4'd0;
            8'hF9:   code = 4'd1;
            8'hA4:   code = 4'd2;
            8'hB0:   code = 4'd3;
            8'h99:   code = 4'd4;
            8'h92:   code = 4'd5;
            8'h82:   code = 4'd6;
            8'hF8:   code = 4'd7;
            8'h80:   code = 4'd8;
            8'h90:   code = 4'd9;
            8'h79:   code = C_ONE_DP;
            8'h24:   code = C_TWO_DP;
            8'h8C:   code = C_P;
            8'hFF:   code = C_BLANK;
            default: code = C_BAD;
        endcase
    end

    // Frame tracker state register
    always_ff @(posedge clk_fst) begin
        if (rst) begin
            state <= WAIT_D0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state from the anode pattern; digit0 always restarts a frame quietly
    always_comb begin
        state_nxt  = state;
        cap_d0     = 1'b0;
        cap_d1     = 1'b0;
        cap_d2     = 1'b0;
        frame_done = 1'b0;
        order_err  = 1'b0;
        case (an)
            4'b1110: begin
                state_nxt = GOT_D0;
                cap_d0    = 1'b1;
            end
            4'b1101: begin
                if (state == GOT_D0) begin
                    state_nxt = GOT_D1;
                    cap_d1    = 1'b1;
                end else begin
                    state_nxt = WAIT_D0;
                    order_err = 1'b1;
                end
            end
            4'b1011: begin
                if (state == GOT_D1) begin
                    state_nxt = GOT_D2;
                    cap_d2    = 1'b1;
                end else begin
                    state_nxt = WAIT_D0;
                    order_err = 1'b1;
                end
            end
            4'b0111: begin
                state_nxt = WAIT_D0;
                if (state == GOT_D2) begin
                    frame_done = 1'b1;
                end else begin
                    order_err = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_D0;
                order_err = 1'b1;
            end
        endcase
    end

    // Digit3 is never stored: the frame is judged on the cycle it arrives
    always_comb begin
        lit_frame   = frame_done && (code == C_P) &&
                      ((d2_code == C_ONE_DP) || (d2_code == C_TWO_DP));
        blank_frame = frame_done && (code == C_BLANK) && (d2_code == C_BLANK) &&
                      (d1_code == C_BLANK) && (d0_code == C_BLANK);
        bad_frame   = frame_done && !lit_frame && !blank_frame;
        digits_num  = (d0_code <= 4'd9) && (d1_code <= 4'd9);
        value       = ({3'b000, d1_code} * 7'd10) + {3'b000, d0_code};
    end

    // Store the codes of digits 0..2 as they arrive in order
    always_ff @(posedge clk_fst) begin
        if (rst) begin
            d0_code <= C_BLANK;
            d1_code <= C_BLANK;
            d2_code <= C_BLANK;
        end else begin
            if (cap_d0) d0_code <= code;
            if (cap_d1) d1_code <= code;
            if (cap_d2) d2_code <= code;
        end
    end

    // Registered results; lit frames update the display values, blank frames only pulse
    always_ff @(posedge clk_fst) begin
        if (rst) begin
            pile_size <= 7'd0;
            pile_vld  <= 1'b0;
            plr_turn  <= 1'b0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            frame_vld <= lit_frame || blank_frame;
            sync_err  <= order_err || bad_frame;
            if (lit_frame) begin
                plr_turn <= (d2_code == C_TWO_DP);
                if (digits_num) begin
                    pile_size <= value;
                    pile_vld  <= 1'b1;
                end else begin
                    pile_vld  <= 1'b0;
                end
            end
        end
    end

`ifdef SEG_DECODE_BLINK_EN
    localparam int CNT_W = (BLINK_TIMEOUT < 2) ? 1 : $clog2(BLINK_TIMEOUT + 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             lit_seen;
    logic             win_q;

    // Blank right after lit means blinking; a run of lit frames ends the win indication
    always_ff @(posedge clk_fst) begin
        if (rst) begin
            blink_cnt <= '0;
            lit_seen  <= 1'b0;
            win_q     <= 1'b0;
        end else if (blank_frame) begin
            blink_cnt <= '0;
            lit_seen  <= 1'b0;
            if (lit_seen) win_q <= 1'b1;
        end else if (lit_frame) begin
            lit_seen <= 1'b1;
            if (win_q) begin
                if (blink_cnt == CNT_W'(BLINK_TIMEOUT - 1)) begin
                    win_q     <= 1'b0;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign win_det = win_q;
`else
    assign win_det = 1'b0;
`endif

endmodule
